apb4_rr_arbiter: RTL

- Shares one APB4 master bus between NREQ internal requesters in front of the APB4 peripheral fabric of the AXI4Lite-to-APB4 bridge.
- Each requester posts a complete command (addr/prot/write/wdata/strb) on a level request.
- The block grants round-robin, runs the APB4 SETUP/ACCESS sequence, and returns PRDATA/PSLVERR with a one-cycle done pulse to the granted requester.

---
 rtl/apb4_rr_arbiter_if.sv | 42 ++++
 rtl/apb4_rr_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb4_rr_arbiter_if.sv
// APB4 bus bundle between apb4_rr_arbiter (master side) and the APB4
// peripheral fabric (slave side). Signal names follow the APB4 convention.
interface apb4_rr_arbiter_if;

    logic        PSELx;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [2:0]  PPROT;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic        PREADY;
    logic        PSLVERR;
    logic [31:0] PRDATA;

    modport master (
        output PSELx,
        output PENABLE,
        output PWRITE,
        output PADDR,
        output PPROT,
        output PWDATA,
        output PSTRB,
        input  PREADY,
        input  PSLVERR,
        input  PRDATA
    );

    modport slave (
        input  PSELx,
        input  PENABLE,
        input  PWRITE,
        input  PADDR,
        input  PPROT,
        input  PWDATA,
        input  PSTRB,
        output PREADY,
        output PSLVERR,
        output PRDATA
    );

endinterface

// File: rtl/apb4_rr_arbiter.sv
// Round-robin arbiter sharing one APB4 master bus between NREQ requesters.
// Each requester posts a full command on a level request; the winner's
// command is latched on the grant edge, driven through SETUP/ACCESS, and the
// response is returned with a one-cycle done pulse. Every output is a flop.
//
// Optional build macro APB_TIMEOUT_EN: adds an ACCESS-phase watchdog that
// abandons a transfer after TIMEOUT_CYCLES wait cycles, answers it with
// rsp_slverr = 1, and pulses timeout_evt together with done.
module apb4_rr_arbiter #(
    parameter int NREQ           = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                 PCLK,
    input  logic                 PRESETn,

    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      req_write,
    input  logic [NREQ*32-1:0]   req_addr,
    input  logic [NREQ*3-1:0]    req_prot,
    input  logic [NREQ*32-1:0]   req_wdata,
    input  logic [NREQ*4-1:0]    req_strb,

    output logic [NREQ-1:0]      done,
    output logic [31:0]          rsp_rdata,
    output logic                 rsp_slverr,
    output logic [2:0]           grant_id,
    output logic                 busy,
`ifdef APB_TIMEOUT_EN
    output logic                 timeout_evt,
`endif

    apb4_rr_arbiter_if.master    apb
);

    // Elaboration guards: index fields are 3 bits wide and the watchdog
    // counter is 8 bits wide.
    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
        $error("apb4_rr_arbiter: NREQ must be within 2..8");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 256) begin : g_bad_timeout
        $error("apb4_rr_arbiter: TIMEOUT_CYCLES must be within 1..256");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_e            state_q,      state_d;
    logic [2:0]        last_q,       last_d;
    logic [2:0]        grant_id_q,   grant_id_d;
    logic              psel_q,       psel_d;
    logic              penable_q,    penable_d;
    logic              pwrite_q,     pwrite_d;
    logic [31:0]       paddr_q,      paddr_d;
    logic [2:0]        pprot_q,      pprot_d;
    logic [31:0]       pwdata_q,     pwdata_d;
    logic [3:0]        pstrb_q,      pstrb_d;
    logic [NREQ-1:0]   done_q,       done_d;
    logic [31:0]       rsp_rdata_q,  rsp_rdata_d;
    logic              rsp_slverr_q, rsp_slverr_d;
    logic              busy_q,       busy_d;
`ifdef APB_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0]        cnt_q,         cnt_d;
    logic              timeout_evt_q, timeout_evt_d;
`endif

    // ------------------------------------------------------------------
    // Round-robin winner search
    // ------------------------------------------------------------------
    logic [7:0]  req_pad;
    logic [3:0]  rr_sum;
    logic        win_found;
    logic [2:0]  win_idx;

    assign req_pad = 8'(req);

    // Scan from last+1 with wrap-around; the first pending request wins.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // through the block can hold a stale value and infer a latch.
        win_found = 1'b0;
        win_idx   = '0;
        rr_sum    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            rr_sum = {1'b0, last_q} + 4'(k);
            if (rr_sum >= 4'(NREQ)) begin
                rr_sum = rr_sum - 4'(NREQ);
            end
            if (!win_found && req_pad[rr_sum[2:0]]) begin
                win_found = 1'b1;
                win_idx   = rr_sum[2:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Winner command select and done decode
    // ------------------------------------------------------------------
    logic              win_write;
    logic [31:0]       win_addr;
    logic [2:0]        win_prot;
    logic [31:0]       win_wdata;
    logic [3:0]        win_strb;
    logic [NREQ-1:0]   grant_onehot;

    // Pull the winning requester's command fields out of the flat buses.
    always_comb begin
        win_write = 1'b0;
        win_addr  = '0;
        win_prot  = '0;
        win_wdata = '0;
        win_strb  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_idx == 3'(i)) begin
                win_write = req_write[i];
                win_addr  = req_addr[32*i +: 32];
                win_prot  = req_prot[3*i +: 3];
                win_wdata = req_wdata[32*i +: 32];
                win_strb  = req_strb[4*i +: 4];
            end
        end
    end

    // One-hot of the current grant, used as the done pattern.
    always_comb begin
        grant_onehot = '0;
        for (int i = 0; i < NREQ; i++) begin
            grant_onehot[i] = (grant_id_q == 3'(i));
        end
    end

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    // IDLE arbitrates and latches, SETUP/ACCESS run the APB phases, DONE
    // presents the response for exactly one cycle.
    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        grant_id_d   = grant_id_q;
        psel_d       = psel_q;
        penable_d    = penable_q;
        pwrite_d     = pwrite_q;
        paddr_d      = paddr_q;
        pprot_d      = pprot_q;
        pwdata_d     = pwdata_q;
        pstrb_d      = pstrb_q;
        done_d       = '0;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_slverr_d = rsp_slverr_q;
`ifdef APB_TIMEOUT_EN
        cnt_d         = cnt_q;
        timeout_evt_d = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    state_d    = S_SETUP;
                    last_d     = win_idx;
                    grant_id_d = win_idx;
                    psel_d     = 1'b1;
                    penable_d  = 1'b0;
                    pwrite_d   = win_write;
                    paddr_d    = win_addr;
                    pprot_d    = win_prot;
                    // Reads present zero data and no strobes on the bus.
                    pwdata_d   = win_write ? win_wdata : 32'd0;
                    pstrb_d    = win_write ? win_strb  : 4'd0;
                end
            end

            S_SETUP: begin
                state_d   = S_ACCESS;
                penable_d = 1'b1;
`ifdef APB_TIMEOUT_EN
                cnt_d     = '0;
`endif
            end

            S_ACCESS: begin
                if (apb.PREADY) begin
                    state_d      = S_DONE;
                    psel_d       = 1'b0;
                    penable_d    = 1'b0;
                    done_d       = grant_onehot;
                    rsp_slverr_d = apb.PSLVERR;
                    rsp_rdata_d  = pwrite_q ? 32'd0 : apb.PRDATA;
                end
`ifdef APB_TIMEOUT_EN
                else if (cnt_q == TIMEOUT_LAST) begin
                    // Slave never answered: abandon and report an error.
                    state_d       = S_DONE;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    done_d        = grant_onehot;
                    rsp_slverr_d  = 1'b1;
                    rsp_rdata_d   = 32'd0;
                    timeout_evt_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // All state and outputs, asynchronously cleared so the bus drops at once.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge values of the others.
            state_q      <= S_IDLE;
            last_q       <= 3'(NREQ - 1);
            grant_id_q   <= '0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            pwrite_q     <= 1'b0;
            paddr_q      <= '0;
            pprot_q      <= '0;
            pwdata_q     <= '0;
            pstrb_q      <= '0;
            done_q       <= '0;
            rsp_rdata_q  <= '0;
            rsp_slverr_q <= 1'b0;
            busy_q       <= 1'b0;
`ifdef APB_TIMEOUT_EN
            cnt_q         <= '0;
            timeout_evt_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            grant_id_q   <= grant_id_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
            pwrite_q     <= pwrite_d;
            paddr_q      <= paddr_d;
            pprot_q      <= pprot_d;
            pwdata_q     <= pwdata_d;
            pstrb_q      <= pstrb_d;
            done_q       <= done_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_slverr_q <= rsp_slverr_d;
            busy_q       <= busy_d;
`ifdef APB_TIMEOUT_EN
            cnt_q         <= cnt_d;
            timeout_evt_q <= timeout_evt_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Output wiring
    // ------------------------------------------------------------------
    assign apb.PSELx   = psel_q;
    assign apb.PENABLE = penable_q;
    assign apb.PWRITE  = pwrite_q;
    assign apb.PADDR   = paddr_q;
    assign apb.PPROT   = pprot_q;
    assign apb.PWDATA  = pwdata_q;
    assign apb.PSTRB   = pstrb_q;

    assign done        = done_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_slverr  = rsp_slverr_q;
    assign grant_id    = grant_id_q;
    assign busy        = busy_q;
`ifdef APB_TIMEOUT_EN
    assign timeout_evt = timeout_evt_q;
`endif

endmodule
